cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 3, number of functional-unit writeback requesters (0=ALU, 1=branch, 2=LSU).
REQ-002 Parameter DEPTH, default 2, per-requester queue entries, power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low: asserted when 0, released synchronously to clk by the system.
REQ-005 flush  input  1  mispredict recovery; synchronous clear of all pending results.
REQ-006 fu_valid  input  [NUM_FU]  requester i offers a completed result this cycle.
REQ-007 fu_entry  input  cdb_entry[NUM_FU]  per-requester result: pd[6:0], rob_index[4:0], data[31:0].
REQ-008 fu_ready  output  [NUM_FU]  queue i can accept; a transfer occurs when fu_valid[i] and fu_ready[i] are both 1 at an edge.
REQ-009 cdb_valid  output  1  registered broadcast valid, one result per cycle.
REQ-010 cdb_out  output  cdb_entry  registered broadcast payload to the ROB, the PRF and the reservation-station wakeup.
REQ-011 cdb_src  output  [$clog2(NUM_FU)]  index of the requester whose result is on cdb_out.

Function
REQ-012 Each requester owns a DEPTH-entry FIFO: read and write pointers wrap modulo DEPTH, plus a count of 0..DEPTH.
REQ-013 fu_ready[i] = (count[i] < DEPTH), derived from registered count only; it does not depend on fu_valid or on the current-cycle grant.
REQ-014 Full FIFO with a pop in the same cycle: fu_ready stays 0; there is no pass-through.
REQ-015 Empty FIFO: no combinational bypass; an entry pushed at edge E is eligible for grant in the cycle after E.
REQ-016 Arbitration: round-robin over the non-empty FIFO heads, searching upward from rr_ptr with wrap past NUM_FU-1.
REQ-017 At most one grant per cycle; the granted head pops at the same edge that loads cdb_out, cdb_src and cdb_valid=1.
REQ-018 After a grant to requester g, rr_ptr becomes (g+1) mod NUM_FU; rr_ptr is unchanged when nothing is granted.
REQ-019 No FIFO non-empty: cdb_valid=0 next cycle, and cdb_out and cdb_src hold their previous values.
REQ-020 Latency: push at edge E, FIFO otherwise empty, won arbitration -> cdb_valid=1 after edge E+1, i.e. one idle cycle of queueing.
REQ-021 Simultaneous push and pop on the same FIFO: count is unchanged, and both pointers advance.
REQ-022 pd=0 (no destination) is broadcast like any other result, because the ROB needs the completion; the arbiter never inspects the payload.
REQ-023 Per-requester order is preserved; cross-requester order is defined only by round-robin.
REQ-024 flush=1 at an edge: all counts and pointers go to 0, cdb_valid=0, rr_ptr=0, and pushes at that edge are discarded (flush has priority over accept).
REQ-025 Starvation bound: a non-empty head is granted within NUM_FU cycles.

Reset
REQ-026 While reset=0: cdb_valid=0, cdb_out='0, cdb_src=0, rr_ptr=0, all counts and pointers 0, so fu_ready is all ones after release.
REQ-027 Reset asserted mid-operation discards all queued results immediately, independent of clk.

Structure
REQ-028 The cdb_entry packed struct and the CDB_NUM_FU constant live in types_pkg, shared with the ROB, PRF and reservation stations.
REQ-029 One sub-module, cdb_fifo (DEPTH entries of cdb_entry, push/pop/count/full/empty), is instantiated NUM_FU times; the arbiter and output register live in cdb_arbiter.
REQ-030 No memories or macros: storage is flops, for a total of roughly 150-300 lines of RTL.

Verification
REQ-031 Single ALU result: pd=5, rob=3, data=0x0000000F pushed at edge E -> cdb_valid=1, cdb_src=0 and the matching payload after E+1, then cdb_valid=0.
REQ-032 All three push at the same edge, rr_ptr=0 (ALU data 0x1, branch 0x2, LSU 0x3) -> broadcasts 0x1, 0x2, 0x3 on consecutive cycles with cdb_src 0, 1, 2.
REQ-033 ALU pushes every cycle while CDB is contended: fu_ready[0] drops to 0 when count reaches 2, no result is lost, and ALU results emerge in push order.
REQ-034 Branch FIFO only, with rr_ptr=2 -> grant wraps to requester 1 without waiting a cycle, and rr_ptr becomes 2.
REQ-035 Two entries queued, flush=1 with a simultaneous push -> cdb_valid=0 next cycle, all fu_ready=1, and neither the flushed nor the pushed result is ever broadcast.
REQ-036 reset driven to 0 between clock edges while FIFOs are non-empty -> outputs go to their reset values without a clock edge, and operation resumes cleanly after release.

Source files
------------

// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared common-data-bus payload type and requester count
package types_pkg;

   // Writeback requesters: 0 = ALU, 1 = branch, 2 = LSU
   localparam int CDB_NUM_FU = 3;

   // Result broadcast to ROB, PRF and reservation-station wakeup
   typedef struct packed {
      logic [6:0]  pd;
      logic [4:0]  rob_index;
      logic [31:0] data;
   } cdb_entry;

endpackage

// File: rtl/cdb_fifo.sv
// rtl/cdb_fifo.sv - flop-based per-requester result queue feeding the CDB arbiter
module cdb_fifo
   import types_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  cdb_entry         push_entry,
   input  logic             pop,
   output cdb_entry         head,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   cdb_entry         mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   // A flush discards anything arriving at the same edge
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   // No bypass: the head is only ever read from stored entries
   assign head    = mem[rd_ptr];

   // Payload storage; contents are don't-care while count says empty
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (do_push && !do_pop) begin
            count <= count + CNT_W'(1);
         end else if (do_pop && !do_push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin writeback arbiter driving the registered CDB broadcast
module cdb_arbiter
   import types_pkg::*;
#(
   parameter  int NUM_FU = CDB_NUM_FU,
   parameter  int DEPTH  = 2,
   localparam int SRC_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
   localparam int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic [NUM_FU-1:0] fu_valid,
   input  cdb_entry          fu_entry [NUM_FU],
   output logic [NUM_FU-1:0] fu_ready,
   output logic              cdb_valid,
   output cdb_entry          cdb_out,
   output logic [SRC_W-1:0]  cdb_src
);

   logic [NUM_FU-1:0] fu_push;
   logic [NUM_FU-1:0] fu_pop;
   logic [NUM_FU-1:0] fifo_empty;
   logic [CNT_W-1:0]  fifo_count [NUM_FU];
   cdb_entry          fifo_head  [NUM_FU];

   logic [SRC_W-1:0]  rr_ptr;
   logic [SRC_W-1:0]  rr_next;
   logic              grant_found;
   logic [SRC_W-1:0]  grant_idx;
   cdb_entry          grant_entry;
   int                cand;
   logic [SRC_W-1:0]  cand_idx;

   for (genvar g = 0; g < NUM_FU; g++) begin : g_fifo
      // Ready comes only from the registered count, never from this cycle's grant
      assign fu_ready[g] = (fifo_count[g] < CNT_W'(DEPTH));
      assign fu_push[g]  = fu_valid[g] & fu_ready[g];

      cdb_fifo #(
         .DEPTH(DEPTH)
      ) u_fifo (
         .clk       (clk),
         .reset     (reset),
         .flush     (flush),
         .push      (fu_push[g]),
         .push_entry(fu_entry[g]),
         .pop       (fu_pop[g]),
         .head      (fifo_head[g]),
         .count     (fifo_count[g]),
         .empty     (fifo_empty[g])
      );
   end

   // Search non-empty heads upward from rr_ptr, wrapping past the last requester
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      cand_idx    = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         cand = int'(rr_ptr) + k;
         if (cand >= NUM_FU) begin
            cand = cand - NUM_FU;
         end
         cand_idx = SRC_W'(cand);
         if (!grant_found && !fifo_empty[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   // One-hot pop of the winning head, suppressed by flush
   always_comb begin
      fu_pop = '0;
      for (int g = 0; g < NUM_FU; g++) begin
         if (grant_found && !flush && (grant_idx == SRC_W'(g))) begin
            fu_pop[g] = 1'b1;
         end
      end
   end

   assign grant_entry = fifo_head[grant_idx];
   assign rr_next     = (grant_idx == SRC_W'(NUM_FU - 1)) ? '0 : grant_idx + SRC_W'(1);

   // Broadcast register and round-robin pointer; payload holds when idle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cdb_valid <= 1'b0;
         cdb_out   <= '0;
         cdb_src   <= '0;
         rr_ptr    <= '0;
      end else if (flush) begin
         cdb_valid <= 1'b0;
         rr_ptr    <= '0;
      end else if (grant_found) begin
         cdb_valid <= 1'b1;
         cdb_out   <= grant_entry;
         cdb_src   <= grant_idx;
         rr_ptr    <= rr_next;
      end else begin
         cdb_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - table and scoreboard bench for the CDB arbiter
module tb_cdb_arbiter;
   import types_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       flush;
   logic [2:0] fu_valid;
   cdb_entry   fu_entry [3];
   logic [2:0] fu_ready;
   logic       cdb_valid;
   cdb_entry   cdb_out;
   logic [1:0] cdb_src;

   int errors = 0;
   int checks = 0;
   cdb_entry exp_q [3][$];

   typedef struct {
      logic       fl;
      logic [2:0] v;
      cdb_entry   e0;
      cdb_entry   e1;
      cdb_entry   e2;
      logic       xv;
      logic [1:0] xs;
      cdb_entry   xo;
      logic [2:0] xr;
   } vec_t;

   vec_t tbl [$];

   always #5 clk = ~clk;

   cdb_arbiter #(
      .NUM_FU(3),
      .DEPTH (2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .fu_valid (fu_valid),
      .fu_entry (fu_entry),
      .fu_ready (fu_ready),
      .cdb_valid(cdb_valid),
      .cdb_out  (cdb_out),
      .cdb_src  (cdb_src)
   );

   function automatic cdb_entry mk(input logic [6:0] pd, input logic [4:0] rob, input logic [31:0] d);
      cdb_entry e;
      e.pd        = pd;
      e.rob_index = rob;
      e.data      = d;
      return e;
   endfunction

   function automatic vec_t row(input logic fl, input logic [2:0] v, input cdb_entry e0, input cdb_entry e1,
                                input cdb_entry e2, input logic xv, input logic [1:0] xs, input cdb_entry xo,
                                input logic [2:0] xr);
      vec_t r;
      r.fl = fl; r.v = v; r.e0 = e0; r.e1 = e1; r.e2 = e2;
      r.xv = xv; r.xs = xs; r.xo = xo; r.xr = xr;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_sb();
      for (int i = 0; i < 3; i++) exp_q[i].delete();
   endtask

   // Drive one cycle, record accepted pushes, then score any broadcast
   task automatic cycle(input logic [2:0] v, input cdb_entry e0, input cdb_entry e1, input cdb_entry e2,
                        input logic fl);
      cdb_entry ents [3];
      ents[0] = e0; ents[1] = e1; ents[2] = e2;
      fu_valid = v;
      fu_entry[0] = e0; fu_entry[1] = e1; fu_entry[2] = e2;
      flush = fl;
      if (fl) begin
         clear_sb();
      end else begin
         for (int i = 0; i < 3; i++)
            if (v[i] && fu_ready[i]) exp_q[i].push_back(ents[i]);
      end
      @(posedge clk);
      #1;
      fu_valid = '0;
      flush = 1'b0;
      if (cdb_valid) begin
         if (cdb_src > 2'd2 || exp_q[cdb_src].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got src %0d data %0h expected no broadcast", cdb_src, cdb_out.data);
         end else begin
            chk("sb_payload", 64'(cdb_out), 64'(exp_q[cdb_src].pop_front()));
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(3'b000, '0, '0, '0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      cdb_entry z;
      cdb_entry a1, b1, c1;
      logic saw_full;
      z = '0;
      reset = 1'b1;
      flush = 1'b0;
      fu_valid = '0;
      for (int i = 0; i < 3; i++) fu_entry[i] = '0;
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 64'(cdb_valid), 64'd0);
      chk("rst_out", 64'(cdb_out), 64'd0);
      chk("rst_src", 64'(cdb_src), 64'd0);
      chk("rst_ready", 64'(fu_ready), 64'h7);
      reset = 1'b1;

      // Single result, then all three, then branch-only wrap from rr_ptr=2
      tbl.push_back(row(0, 3'b001, mk(5, 3, 32'hF), z, z, 0, 0, z, 3'b111));
      tbl.push_back(row(0, 3'b000, z, z, z, 1, 0, mk(5, 3, 32'hF), 3'b111));
      tbl.push_back(row(0, 3'b000, z, z, z, 0, 0, mk(5, 3, 32'hF), 3'b111));
      tbl.push_back(row(1, 3'b000, z, z, z, 0, 0, mk(5, 3, 32'hF), 3'b111));
      tbl.push_back(row(0, 3'b111, mk(1, 1, 32'h1), mk(0, 2, 32'h2), mk(3, 3, 32'h3), 0, 0, mk(5, 3, 32'hF), 3'b111));
      tbl.push_back(row(0, 3'b000, z, z, z, 1, 0, mk(1, 1, 32'h1), 3'b111));
      tbl.push_back(row(0, 3'b000, z, z, z, 1, 1, mk(0, 2, 32'h2), 3'b111));
      tbl.push_back(row(0, 3'b000, z, z, z, 1, 2, mk(3, 3, 32'h3), 3'b111));
      tbl.push_back(row(0, 3'b000, z, z, z, 0, 2, mk(3, 3, 32'h3), 3'b111));
      tbl.push_back(row(0, 3'b010, z, mk(10, 10, 32'hA), z, 0, 2, mk(3, 3, 32'h3), 3'b111));
      tbl.push_back(row(0, 3'b000, z, z, z, 1, 1, mk(10, 10, 32'hA), 3'b111));
      tbl.push_back(row(0, 3'b010, z, mk(11, 11, 32'hB), z, 0, 1, mk(10, 10, 32'hA), 3'b111));
      tbl.push_back(row(0, 3'b000, z, z, z, 1, 1, mk(11, 11, 32'hB), 3'b111));
      tbl.push_back(row(0, 3'b111, mk(21, 1, 32'h21), mk(22, 2, 32'h22), mk(23, 3, 32'h23), 0, 1, mk(11, 11, 32'hB), 3'b111));
      tbl.push_back(row(0, 3'b000, z, z, z, 1, 2, mk(23, 3, 32'h23), 3'b111));
      tbl.push_back(row(0, 3'b000, z, z, z, 1, 0, mk(21, 1, 32'h21), 3'b111));
      tbl.push_back(row(0, 3'b000, z, z, z, 1, 1, mk(22, 2, 32'h22), 3'b111));
      tbl.push_back(row(0, 3'b000, z, z, z, 0, 1, mk(22, 2, 32'h22), 3'b111));

      for (int i = 0; i < tbl.size(); i++) begin
         cycle(tbl[i].v, tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].fl);
         chk($sformatf("row%0d_valid", i), 64'(cdb_valid), 64'(tbl[i].xv));
         chk($sformatf("row%0d_src", i), 64'(cdb_src), 64'(tbl[i].xs));
         chk($sformatf("row%0d_out", i), 64'(cdb_out), 64'(tbl[i].xo));
         chk($sformatf("row%0d_ready", i), 64'(fu_ready), 64'(tbl[i].xr));
      end

      // Contention: every requester pushes every cycle, ALU must see backpressure
      cycle(3'b000, z, z, z, 1'b1);
      saw_full = 1'b0;
      for (int n = 0; n < 12; n++) begin
         cycle(3'b111, mk(7'(n), 5'(n), 32'hA000 + n), mk(7'(n), 5'(n), 32'hB000 + n),
               mk(7'(n), 5'(n), 32'hC000 + n), 1'b0);
         if (!fu_ready[0]) saw_full = 1'b1;
      end
      chk("alu_backpressure", 64'(saw_full), 64'd1);
      idle(8);
      chk("drain_alu", 64'(exp_q[0].size()), 64'd0);
      chk("drain_br", 64'(exp_q[1].size()), 64'd0);
      chk("drain_lsu", 64'(exp_q[2].size()), 64'd0);
      chk("drain_ready", 64'(fu_ready), 64'h7);
      chk("drain_valid", 64'(cdb_valid), 64'd0);

      // Flush with queued entries and a simultaneous push
      a1 = mk(31, 1, 32'h31);
      b1 = mk(32, 2, 32'h32);
      c1 = mk(33, 3, 32'h33);
      cycle(3'b011, a1, b1, z, 1'b0);
      chk("pre_flush_valid", 64'(cdb_valid), 64'd0);
      cycle(3'b111, mk(41, 1, 32'h41), mk(42, 2, 32'h42), c1, 1'b1);
      chk("flush_valid", 64'(cdb_valid), 64'd0);
      chk("flush_ready", 64'(fu_ready), 64'h7);
      for (int i = 0; i < 4; i++) begin
         cycle(3'b000, z, z, z, 1'b0);
         chk($sformatf("post_flush_valid%0d", i), 64'(cdb_valid), 64'd0);
      end

      // Asynchronous reset mid-operation
      cycle(3'b111, a1, b1, c1, 1'b0);
      cycle(3'b000, z, z, z, 1'b0);
      chk("pre_reset_valid", 64'(cdb_valid), 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("async_valid", 64'(cdb_valid), 64'd0);
      chk("async_out", 64'(cdb_out), 64'd0);
      chk("async_src", 64'(cdb_src), 64'd0);
      chk("async_ready", 64'(fu_ready), 64'h7);
      clear_sb();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("resume_idle", 64'(cdb_valid), 64'd0);
      cycle(3'b100, z, z, mk(9, 9, 32'h99), 1'b0);
      chk("resume_push_valid", 64'(cdb_valid), 64'd0);
      cycle(3'b000, z, z, z, 1'b0);
      chk("resume_valid", 64'(cdb_valid), 64'd1);
      chk("resume_src", 64'(cdb_src), 64'd2);
      chk("resume_out", 64'(cdb_out), 64'(mk(9, 9, 32'h99)));
      idle(2);
      chk("resume_drain", 64'(exp_q[2].size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
